timer_arbiter: RTL

TIMER_ARBITER -- requirements
Module: timer_arbiter

---
 rtl/timer_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/timer_arbiter.sv
// timer_arbiter: four requesters share a single up-counting timer.
// Ownership is granted round-robin, starting the search just after the last
// owner. The owner's terminal count is captured when the grant is issued. The
// timer then counts from 0 up to that limit inclusive, and the owner receives
// a one-cycle done pulse.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no owner; oCount keeps its last value; arbitrate on any iReq
//   ST_LOAD  | winner granted, oCount cleared, limit already captured
//   ST_COUNT | oCount advances once per cycle unless iHold is high
//   ST_DONE  | oDone mirrors oGrant for this single cycle
//
// If the owner drops its request in LOAD or COUNT, the grant is abandoned at
// once. There is no done pulse, and the arbitration pointer still moves past
// the owner, so a dropped request cannot monopolise priority.
module timer_arbiter #(
    parameter int SIZE = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [3:0]        iReq,
    input  logic [4*SIZE-1:0] iLimit,
    input  logic              iHold,
    output logic [3:0]        oGrant,
    output logic [3:0]        oDone,
    output logic              oBusy,
    output logic [SIZE-1:0]   oCount
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    logic [3:0]        r_grant;
    logic [3:0]        r_done;
    logic              r_busy;
    logic [SIZE-1:0]   r_count;
    logic [SIZE-1:0]   r_limit;
    logic [1:0]        r_owner;
    logic [1:0]        r_last;

    state_t            w_state_nxt;
    logic [3:0]        w_grant_nxt;
    logic [3:0]        w_done_nxt;
    logic [SIZE-1:0]   w_count_nxt;
    logic [SIZE-1:0]   w_limit_nxt;
    logic [1:0]        w_owner_nxt;
    logic [1:0]        w_last_nxt;

    logic [1:0]        w_win;
    logic [1:0]        w_idx;
    logic [SIZE-1:0]   w_win_limit;
    logic              w_owner_req;

    // Round-robin pick: the loop walks down, so the nearest requester after r_last wins.
    always_comb begin
        w_win = r_last + 2'd1;
        w_idx = r_last + 2'd1;
        for (int k = 4; k >= 1; k--) begin
            w_idx = r_last + 2'(k);
            if (iReq[w_idx]) begin
                w_win = w_idx;
            end
        end
    end

    // Select the winner's terminal-count field.
    always_comb begin
        w_win_limit = iLimit[0 +: SIZE];
        case (w_win)
            2'd0: w_win_limit = iLimit[0*SIZE +: SIZE];
            2'd1: w_win_limit = iLimit[1*SIZE +: SIZE];
            2'd2: w_win_limit = iLimit[2*SIZE +: SIZE];
            2'd3: w_win_limit = iLimit[3*SIZE +: SIZE];
            default: w_win_limit = iLimit[0 +: SIZE];
        endcase
    end

    assign w_owner_req = iReq[r_owner];

    // Next-state and next-output logic; an abort outranks both the limit match and iHold.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_done_nxt  = 4'b0000;
        w_count_nxt = r_count;
        w_limit_nxt = r_limit;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        case (r_state)
            ST_IDLE: begin
                if (|iReq) begin
                    w_state_nxt = ST_LOAD;
                    w_grant_nxt = 4'b0001 << w_win;
                    w_count_nxt = '0;
                    w_limit_nxt = w_win_limit;
                    w_owner_nxt = w_win;
                end
            end
            ST_LOAD: begin
                if (!w_owner_req) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = 4'b0000;
                    w_last_nxt  = r_owner;
                end else begin
                    w_state_nxt = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (!w_owner_req) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = 4'b0000;
                    w_last_nxt  = r_owner;
                end else if (!iHold) begin
                    if (r_count == r_limit) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = r_grant;
                    end else begin
                        w_count_nxt = r_count + {{(SIZE-1){1'b0}}, 1'b1};
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 4'b0000;
                w_last_nxt  = r_owner;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 4'b0000;
            end
        endcase
    end

    // State and output registers; reset leaves requester 0 next in line.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_grant <= 4'b0000;
            r_done  <= 4'b0000;
            r_busy  <= 1'b0;
            r_count <= '0;
            r_limit <= '0;
            r_owner <= 2'd0;
            r_last  <= 2'd3;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_count <= w_count_nxt;
            r_limit <= w_limit_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign oGrant = r_grant;
    assign oDone  = r_done;
    assign oBusy  = r_busy;
    assign oCount = r_count;

endmodule
